// File: rtl/vga_floor_pkg.sv
// rtl/vga_floor_pkg.sv - 640x480@60 timing constants, pixel divide ratio and slide FSM states.
package vga_floor_pkg;

  localparam int H_ACTIVE = 640;
  localparam int H_FRONT  = 16;
  localparam int H_SYNC   = 96;
  localparam int H_TOTAL  = 800;

  localparam int V_ACTIVE = 480;
  localparam int V_FRONT  = 10;
  localparam int V_SYNC   = 2;
  localparam int V_TOTAL  = 525;

  // Lines outside [LINE_FIRST, LINE_LAST] are always black.
  localparam int LINE_FIRST = 40;
  localparam int LINE_LAST  = 440;

  localparam int PIX_DIV = 4;
  localparam int CNT_W   = 10;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_SLIDE_UP = 2'd1,
    ST_SLIDE_DN = 2'd2
  } slide_state_t;

endpackage

// File: rtl/vga_floor_display_if.sv
// rtl/vga_floor_display_if.sv - floor request, image ROM port and VGA pins of the floor display.
interface vga_floor_display_if #(
  parameter int N_FLOORS = 4,
  parameter int IMG_W    = 75,
  parameter int IMG_H    = 90
);
  localparam int FW = $clog2(N_FLOORS);
  localparam int AW = $clog2(IMG_W * IMG_H);

  logic [FW-1:0] now_floor;
  logic [11:0]   rom_data;
  logic [FW-1:0] rom_sel;
  logic [AW-1:0] rom_addr;
  logic [3:0]    vgaRed;
  logic [3:0]    vgaGreen;
  logic [3:0]    vgaBlue;
  logic          hsync;
  logic          vsync;
  logic          busy;

  modport master (
    input  now_floor, rom_data,
    output rom_sel, rom_addr, vgaRed, vgaGreen, vgaBlue, hsync, vsync, busy
  );

  modport slave (
    output now_floor, rom_data,
    input  rom_sel, rom_addr, vgaRed, vgaGreen, vgaBlue, hsync, vsync, busy
  );
endinterface

// File: rtl/vga_floor_display_timing.sv
// rtl/vga_floor_display_timing.sv - vga_timing: pixel enable, h/v counters, syncs, active flag, frame strobe.
module vga_timing #(
  parameter int PIX_DIV = vga_floor_pkg::PIX_DIV,
  parameter int H_ACT   = vga_floor_pkg::H_ACTIVE,
  parameter int H_FP    = vga_floor_pkg::H_FRONT,
  parameter int H_SW    = vga_floor_pkg::H_SYNC,
  parameter int H_TOT   = vga_floor_pkg::H_TOTAL,
  parameter int V_ACT   = vga_floor_pkg::V_ACTIVE,
  parameter int V_FP    = vga_floor_pkg::V_FRONT,
  parameter int V_SW    = vga_floor_pkg::V_SYNC,
  parameter int V_TOT   = vga_floor_pkg::V_TOTAL
) (
  input  logic                           clk,
  input  logic                           rst,
  output logic                           pix_en,
  output logic [vga_floor_pkg::CNT_W-1:0] h_cnt,
  output logic [vga_floor_pkg::CNT_W-1:0] v_cnt,
  output logic                           hsync_n,
  output logic                           vsync_n,
  output logic                           active,
  output logic                           frame_start
);
  localparam int CW   = vga_floor_pkg::CNT_W;
  localparam int PH_W = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;

  logic [PH_W-1:0] phase;
  int              hx;
  int              vy;

  assign pix_en = (phase == PH_W'(PIX_DIV - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      phase <= '0;
      h_cnt <= '0;
      v_cnt <= '0;
    end else begin
      phase <= pix_en ? '0 : phase + 1'b1;
      if (pix_en) begin
        if (h_cnt == CW'(H_TOT - 1)) begin
          h_cnt <= '0;
          v_cnt <= (v_cnt == CW'(V_TOT - 1)) ? '0 : v_cnt + 1'b1;
        end else begin
          h_cnt <= h_cnt + 1'b1;
        end
      end
    end
  end

  assign hx          = int'(h_cnt);
  assign vy          = int'(v_cnt);
  assign hsync_n     = !((hx >= H_ACT + H_FP) && (hx < H_ACT + H_FP + H_SW));
  assign vsync_n     = !((vy >= V_ACT + V_FP) && (vy < V_ACT + V_FP + V_SW));
  assign active      = (hx < H_ACT) && (vy < V_ACT);
  assign frame_start = pix_en && (h_cnt == '0) && (v_cnt == '0);
endmodule

// File: rtl/vga_floor_display.sv
// rtl/vga_floor_display.sv - elevator floor image window with vertical slide between floors.
// Optional VGA_FLOOR_BORDER_EN draws a 2-pixel white frame around the window.
module vga_floor_display
  import vga_floor_pkg::*;
#(
  parameter int N_FLOORS   = 4,
  parameter int IMG_W      = 75,
  parameter int IMG_H      = 90,
  parameter int WIN_X0     = 405,
  parameter int WIN_Y0     = 150,
  parameter int SLIDE_STEP = 3,
  parameter int H_ACT      = H_ACTIVE,
  parameter int H_FP       = H_FRONT,
  parameter int H_SW       = H_SYNC,
  parameter int H_TOT      = H_TOTAL,
  parameter int V_ACT      = V_ACTIVE,
  parameter int V_FP       = V_FRONT,
  parameter int V_SW       = V_SYNC,
  parameter int V_TOT      = V_TOTAL,
  parameter int LINE_LO    = LINE_FIRST,
  parameter int LINE_HI    = LINE_LAST
) (
  input  logic                clk,
  input  logic                rst,
  vga_floor_display_if.master bus
);
  localparam int FW = $clog2(N_FLOORS);
  localparam int AW = $clog2(IMG_W * IMG_H);
  localparam int OW = $clog2(IMG_H + 1);

  logic             pix_en;
  logic [CNT_W-1:0] h_cnt;
  logic [CNT_W-1:0] v_cnt;
  logic             hsync_n;
  logic             vsync_n;
  logic             active;
  logic             frame_start;

  slide_state_t     state, state_nx;
  logic [FW-1:0]    cur_floor, cur_floor_nx;
  logic [FW-1:0]    tgt_floor, tgt_floor_nx;
  logic [OW-1:0]    offset, offset_nx;

  int               hx, vy, col, row, off_i, src_row, addr_i;
  logic [FW-1:0]    src_floor;
  logic             in_win, in_ring, show;

  logic [11:0]      rgb_q;
  logic             hsync_q;
  logic             vsync_q;

  vga_timing #(
    .PIX_DIV(PIX_DIV),
    .H_ACT(H_ACT), .H_FP(H_FP), .H_SW(H_SW), .H_TOT(H_TOT),
    .V_ACT(V_ACT), .V_FP(V_FP), .V_SW(V_SW), .V_TOT(V_TOT)
  ) u_timing (
    .clk        (clk),
    .rst        (rst),
    .pix_en     (pix_en),
    .h_cnt      (h_cnt),
    .v_cnt      (v_cnt),
    .hsync_n    (hsync_n),
    .vsync_n    (vsync_n),
    .active     (active),
    .frame_start(frame_start)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      cur_floor <= '0;
      tgt_floor <= '0;
      offset    <= '0;
    end else begin
      state     <= state_nx;
      cur_floor <= cur_floor_nx;
      tgt_floor <= tgt_floor_nx;
      offset    <= offset_nx;
    end
  end

  // Floor requests are only looked at on the frame-start tick, so a slide never restarts mid-frame.
  always_comb begin
    state_nx     = state;
    cur_floor_nx = cur_floor;
    tgt_floor_nx = tgt_floor;
    offset_nx    = offset;
    if (frame_start) begin
      case (state)
        ST_IDLE: begin
          if ((bus.now_floor != cur_floor) && (int'(bus.now_floor) < N_FLOORS)) begin
            tgt_floor_nx = bus.now_floor;
            offset_nx    = '0;
            state_nx     = (bus.now_floor > cur_floor) ? ST_SLIDE_UP : ST_SLIDE_DN;
          end
        end
        ST_SLIDE_UP, ST_SLIDE_DN: begin
          if (int'(offset) + SLIDE_STEP >= IMG_H) begin
            cur_floor_nx = tgt_floor;
            offset_nx    = '0;
            state_nx     = ST_IDLE;
          end else begin
            offset_nx = offset + OW'(SLIDE_STEP);
          end
        end
        default: state_nx = ST_IDLE;
      endcase
    end
  end

  // Pixel source: which image and row feeds screen row r for the current slide position.
  always_comb begin
    hx        = int'(h_cnt);
    vy        = int'(v_cnt);
    off_i     = int'(offset);
    in_win    = (hx >= WIN_X0) && (hx < WIN_X0 + 2 * IMG_W) &&
                (vy >= WIN_Y0) && (vy < WIN_Y0 + 2 * IMG_H);
    col       = (hx - WIN_X0) >>> 1;
    row       = (vy - WIN_Y0) >>> 1;
    src_floor = cur_floor;
    src_row   = row;
    case (state)
      ST_SLIDE_UP: begin
        if (row + off_i < IMG_H) begin
          src_row = row + off_i;
        end else begin
          src_floor = tgt_floor;
          src_row   = row + off_i - IMG_H;
        end
      end
      ST_SLIDE_DN: begin
        if (row < off_i) begin
          src_floor = tgt_floor;
          src_row   = row + IMG_H - off_i;
        end else begin
          src_row = row - off_i;
        end
      end
      default: ;
    endcase
    addr_i = in_win ? (src_row * IMG_W + col) : 0;
    show   = active && (vy >= LINE_LO) && (vy <= LINE_HI);
`ifdef VGA_FLOOR_BORDER_EN
    in_ring = !in_win &&
              (hx >= WIN_X0 - 2) && (hx < WIN_X0 + 2 * IMG_W + 2) &&
              (vy >= WIN_Y0 - 2) && (vy < WIN_Y0 + 2 * IMG_H + 2);
`else
    in_ring = 1'b0;
`endif
  end

  assign bus.rom_sel  = src_floor;
  assign bus.rom_addr = AW'(addr_i);

  // rom_data reflects the address set up at the previous tick, so RGB trails the counters by one tick.
  always_ff @(posedge clk) begin
    if (rst) begin
      rgb_q   <= 12'h000;
      hsync_q <= 1'b1;
      vsync_q <= 1'b1;
    end else if (pix_en) begin
      if (!show)        rgb_q <= 12'h000;
      else if (in_win)  rgb_q <= bus.rom_data;
      else if (in_ring) rgb_q <= 12'hFFF;
      else              rgb_q <= 12'h000;
      hsync_q <= hsync_n;
      vsync_q <= vsync_n;
    end
  end

  assign bus.vgaRed   = rgb_q[11:8];
  assign bus.vgaGreen = rgb_q[7:4];
  assign bus.vgaBlue  = rgb_q[3:0];
  assign bus.hsync    = hsync_q;
  assign bus.vsync    = vsync_q;
  assign bus.busy     = (state != ST_IDLE);
endmodule

// File: tb/tb_vga_floor_display.sv
// tb/tb_vga_floor_display.sv - randomized floor requests against a per-pixel reference model on a shrunk raster.
module tb_vga_floor_display;
  localparam int NF = 5, IW = 4, IH = 7, WX = 5, WY = 4, STEP = 3;
  localparam int HA = 20, HF = 2, HS = 3, HT = 26;
  localparam int VA = 22, VF = 1, VS = 2, VT = 26;
  localparam int VMIN = 3, VMAX = 18;
  localparam int FW = $clog2(NF);
  localparam int FRAME_CLK = HT * VT * 4;

  typedef struct {
    logic [11:0] rgb;
    logic        hs;
    logic        vs;
    logic        busy;
    int          h;
    int          v;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;
  exp_t q[$];
  exp_t me;
  exp_t ce;

  int m_phase, m_h, m_v, m_cur, m_tgt, m_off, m_mode;

  int steps[7] = '{2, 1, 7, 4, 5, 3, 0};
  int holds[7] = '{2, 3, 2, 2, 2, 3, 1};

  always #5 clk = ~clk;

  vga_floor_display_if #(.N_FLOORS(NF), .IMG_W(IW), .IMG_H(IH)) bus ();

  vga_floor_display #(
    .N_FLOORS(NF), .IMG_W(IW), .IMG_H(IH), .WIN_X0(WX), .WIN_Y0(WY), .SLIDE_STEP(STEP),
    .H_ACT(HA), .H_FP(HF), .H_SW(HS), .H_TOT(HT),
    .V_ACT(VA), .V_FP(VF), .V_SW(VS), .V_TOT(VT),
    .LINE_LO(VMIN), .LINE_HI(VMAX)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always @(posedge clk) bus.rom_data <= {4'(bus.rom_sel), 8'(bus.rom_addr)};

  // Slide view as a window over a virtual strip: up = [cur ; tgt], down = [tgt ; cur].
  function automatic logic [11:0] ref_pixel(int h, int v);
    int c, r, fl, vr;
    if (h >= HA || v >= VA || v < VMIN || v > VMAX) return 12'h000;
    if (h >= WX && h < WX + 2 * IW && v >= WY && v < WY + 2 * IH) begin
      c = (h - WX) / 2;
      r = (v - WY) / 2;
      if (m_mode == 0) begin
        fl = m_cur; vr = r;
      end else if (m_mode > 0) begin
        vr = r + m_off;
        fl = (vr < IH) ? m_cur : m_tgt;
        vr = vr % IH;
      end else begin
        vr = r - m_off + IH;
        fl = (vr < IH) ? m_tgt : m_cur;
        vr = vr % IH;
      end
      return {4'(fl), 8'(vr * IW + c)};
    end
`ifdef VGA_FLOOR_BORDER_EN
    if (h >= WX - 2 && h < WX + 2 * IW + 2 && v >= WY - 2 && v < WY + 2 * IH + 2) return 12'hFFF;
`endif
    return 12'h000;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_phase = 0; m_h = 0; m_v = 0;
      m_cur = 0; m_tgt = 0; m_off = 0; m_mode = 0;
      me.rgb = 12'h000; me.hs = 1'b1; me.vs = 1'b1; me.busy = 1'b0; me.h = -1; me.v = -1;
      q.push_back(me);
    end else begin
      if (m_phase == 3) begin
        me.rgb = ref_pixel(m_h, m_v);
        me.hs  = !(m_h >= HA + HF && m_h < HA + HF + HS);
        me.vs  = !(m_v >= VA + VF && m_v < VA + VF + VS);
        me.h   = m_h;
        me.v   = m_v;
        if (m_h == 0 && m_v == 0) begin
          if (m_mode == 0) begin
            if (int'(bus.now_floor) < NF && int'(bus.now_floor) != m_cur) begin
              m_tgt  = int'(bus.now_floor);
              m_off  = 0;
              m_mode = (m_tgt > m_cur) ? 1 : -1;
            end
          end else begin
            m_off = (m_off + STEP > IH) ? IH : m_off + STEP;
            if (m_off == IH) begin
              m_cur = m_tgt; m_off = 0; m_mode = 0;
            end
          end
        end
        me.busy = (m_mode != 0);
        q.push_back(me);
        m_h = m_h + 1;
        if (m_h == HT) begin
          m_h = 0;
          m_v = (m_v + 1) % VT;
        end
      end
      m_phase = (m_phase + 1) % 4;
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      while (q.size() > 0) begin
        ce = q.pop_front();
        checks++;
        if ({bus.vgaRed, bus.vgaGreen, bus.vgaBlue} !== ce.rgb || bus.hsync !== ce.hs ||
            bus.vsync !== ce.vs || bus.busy !== ce.busy) begin
          failures++;
          $display("FAIL pixel h=%0d v=%0d got rgb=%03h hs=%0b vs=%0b busy=%0b required rgb=%03h hs=%0b vs=%0b busy=%0b",
                   ce.h, ce.v, {bus.vgaRed, bus.vgaGreen, bus.vgaBlue}, bus.hsync, bus.vsync, bus.busy,
                   ce.rgb, ce.hs, ce.vs, ce.busy);
        end
      end
    end
  end

  initial begin
    int n;
    bus.now_floor = '0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (FRAME_CLK) @(negedge clk);

    for (int i = 0; i < 7; i++) begin
      bus.now_floor = FW'(steps[i]);
      repeat (holds[i] * FRAME_CLK + $urandom_range(FRAME_CLK / 2, 0)) @(negedge clk);
    end

    bus.now_floor = FW'(4);
    n = 0;
    while (bus.busy !== 1'b1 && n < 5 * FRAME_CLK) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (bus.busy !== 1'b1) begin
      failures++;
      $display("FAIL busy_wait got busy=%0b required 1", bus.busy);
    end
    repeat (FRAME_CLK + $urandom_range(FRAME_CLK / 4, 0)) @(negedge clk);
    rst = 1'b1;
    bus.now_floor = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (2 * FRAME_CLK) @(negedge clk);

    repeat (5) @(negedge clk);
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL queue_drain got %0d pending required 0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/vga_floor_display.md
VGA_FLOOR_DISPLAY -- requirements
Module: vga_floor_display

Interface
REQ-001 SHALL have parameter N_FLOORS, default 4, number of floor images (2..16).
REQ-002 SHALL have parameter IMG_W, default 75, stored image width in pixels.
REQ-003 SHALL have parameter IMG_H, default 90, stored image height in pixels.
REQ-004 SHALL have parameter WIN_X0, default 405, window left edge, screen pixels.
REQ-005 SHALL have parameter WIN_Y0, default 150, window top edge, screen lines.
REQ-006 SHALL have parameter SLIDE_STEP, default 3, image rows advanced per frame during a transition.
REQ-007 SHALL have ports: clk in 1 system clock 100 MHz; rst in 1 synchronous active-high reset.
REQ-008 SHALL have ports: now_floor in FW=$clog2(N_FLOORS) requested floor; rom_data in 12 pixel from the selected image ROM.
REQ-009 SHALL have ports: rom_sel out FW image select; rom_addr out $clog2(IMG_W*IMG_H) image address.
REQ-010 SHALL have ports: vgaRed/vgaGreen/vgaBlue out 4 each; hsync, vsync out 1 active-low; busy out 1 transition in progress.

Function
REQ-011 SHALL assert an internal pixel enable pix_en on every 4th clk; all counters and outputs SHALL update only on pix_en.
REQ-012 SHALL generate 640x480@60 timing: h total 800 (sync 656..751), v total 525 (sync 490..491); h_cnt/v_cnt wrap to 0.
REQ-013 SHALL define the window as h in [WIN_X0, WIN_X0+2*IMG_W), v in [WIN_Y0, WIN_Y0+2*IMG_H); image coordinates are c=(h-WIN_X0)>>1, r=(v-WIN_Y0)>>1.
REQ-014 SHALL drive rom_addr/rom_sel combinationally from the current counters; rom_data is valid 1 clk later (ROM latency 1).
REQ-015 SHALL register RGB, hsync, vsync on pix_en from the pre-advance counters: output latency exactly one pixel tick, RGB/sync aligned.
REQ-016 SHALL output RGB 12'h000 outside the window, outside the 640x480 active area, and on lines v<40 or v>440.
REQ-017 SHALL implement FSM IDLE/SLIDE_UP/SLIDE_DN with registers cur_floor, tgt_floor, offset (0..IMG_H).
REQ-018 IDLE: at frame start (h=0,v=0 tick) if now_floor!=cur_floor and now_floor<N_FLOORS, SHALL latch tgt_floor, offset=0, go SLIDE_UP if now_floor>cur_floor else SLIDE_DN.
REQ-019 SLIDE_UP: row r SHALL show cur_floor row r+offset if r+offset<IMG_H, else tgt_floor row r+offset-IMG_H.
REQ-020 SLIDE_DN: row r SHALL show tgt_floor row r+IMG_H-offset if r<offset, else cur_floor row r-offset.
REQ-021 In SLIDE_*, at each frame start offset SHALL add SLIDE_STEP, saturating at IMG_H; on reaching IMG_H SHALL set cur_floor=tgt_floor, offset=0, return IDLE the same tick.
REQ-022 now_floor changes during SLIDE_* SHALL be ignored; re-evaluated in IDLE at the next frame start.
REQ-023 now_floor>=N_FLOORS SHALL be ignored (display holds).
REQ-024 busy SHALL be 1 exactly while state!=IDLE.

Reset
REQ-025 On rst: h_cnt=v_cnt=0, pix_en phase=0, RGB=0, hsync=vsync=1, cur_floor=tgt_floor=0, offset=0, state IDLE, busy=0.
REQ-026 rst mid-transition SHALL abort the slide; the next frame shows floor 0.

Configuration
REQ-027 With VGA_FLOOR_BORDER_EN defined, SHALL draw a 2-pixel 12'hFFF border immediately outside the window (RGB only, inside active area); without it, those pixels are 12'h000. Timing and FSM unaffected.

Structure
REQ-028 Package vga_floor_pkg SHALL hold the timing constants (H/V active, front porch, sync, total), the FSM state enum, and the pixel-enable divide ratio.
REQ-029 Sub-module vga_timing (counters, sync, active flag, frame-start strobe) SHALL be instantiated once.

Verification
REQ-030 Reset then run 2 frames -> hsync period 3200 clk, low 384 clk; vsync low 2 lines; RGB 0 outside window.
REQ-031 ROM model returns {floor,addr[7:0]}; now_floor=0 -> pixel (405,150) shows 12'h000 at addr 0, (407,150) addr 1, (405,152) addr 75.
REQ-032 now_floor 0->2 -> busy within 1 frame; row 0 at frame k shows floor 0 row 3k; busy drops after 30 frames; cur_floor=2.
REQ-033 now_floor 3->1 -> SLIDE_DN; frame 1 rows 0..2 from floor 1 rows 87..89, row 3 from floor 3 row 0.
REQ-034 now_floor toggles 1 then 2 mid-slide, and now_floor=5 with N_FLOORS=5 -> second request served after first completes; out-of-range ignored.
REQ-035 rst asserted at slide frame 10 -> all outputs at reset values next clk; floor 0 shown afterwards; border present only with VGA_FLOOR_BORDER_EN.
